// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the bus CPU control unit: control-bit positions, opcodes and
// the fixed fetch words.
package cpu_ctrl_pkg;

  localparam int unsigned CTRL_W = 16;

  localparam int unsigned B_HLT = 15;
  localparam int unsigned B_MI  = 14;
  localparam int unsigned B_RI  = 13;
  localparam int unsigned B_RO  = 12;
  localparam int unsigned B_IO  = 11;
  localparam int unsigned B_II  = 10;
  localparam int unsigned B_AI  = 9;
  localparam int unsigned B_AO  = 8;
  localparam int unsigned B_EO  = 7;
  localparam int unsigned B_SU  = 6;
  localparam int unsigned B_BI  = 5;
  localparam int unsigned B_OI  = 4;
  localparam int unsigned B_CE  = 3;
  localparam int unsigned B_CO  = 2;
  localparam int unsigned B_J   = 1;
  localparam int unsigned B_FI  = 0;

  localparam logic [CTRL_W-1:0] M_HLT = CTRL_W'(1) << B_HLT;
  localparam logic [CTRL_W-1:0] M_MI  = CTRL_W'(1) << B_MI;
  localparam logic [CTRL_W-1:0] M_RI  = CTRL_W'(1) << B_RI;
  localparam logic [CTRL_W-1:0] M_RO  = CTRL_W'(1) << B_RO;
  localparam logic [CTRL_W-1:0] M_IO  = CTRL_W'(1) << B_IO;
  localparam logic [CTRL_W-1:0] M_II  = CTRL_W'(1) << B_II;
  localparam logic [CTRL_W-1:0] M_AI  = CTRL_W'(1) << B_AI;
  localparam logic [CTRL_W-1:0] M_AO  = CTRL_W'(1) << B_AO;
  localparam logic [CTRL_W-1:0] M_EO  = CTRL_W'(1) << B_EO;
  localparam logic [CTRL_W-1:0] M_SU  = CTRL_W'(1) << B_SU;
  localparam logic [CTRL_W-1:0] M_BI  = CTRL_W'(1) << B_BI;
  localparam logic [CTRL_W-1:0] M_OI  = CTRL_W'(1) << B_OI;
  localparam logic [CTRL_W-1:0] M_CE  = CTRL_W'(1) << B_CE;
  localparam logic [CTRL_W-1:0] M_CO  = CTRL_W'(1) << B_CO;
  localparam logic [CTRL_W-1:0] M_J   = CTRL_W'(1) << B_J;
  localparam logic [CTRL_W-1:0] M_FI  = CTRL_W'(1) << B_FI;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [CTRL_W-1:0] FETCH_T0 = M_CO | M_MI;
  localparam logic [CTRL_W-1:0] FETCH_T1 = M_RO | M_II | M_CE;

  typedef enum logic {StRun, StHalt} seq_state_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps opcode, T-step and the latched flags to a control word.
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned STEP_W   = 3
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [STEP_W-1:0]   i_step,
  input  logic                i_cf,
  input  logic                i_zf,
  output logic [CTRL_W-1:0]   o_word
);

  logic [CTRL_W-1:0] w_t2, w_t3, w_t4;

  always_comb begin
    w_t2 = '0;
    w_t3 = '0;
    w_t4 = '0;
    case (i_opcode)
      OP_LDA: begin
        w_t2 = M_MI | M_IO;
        w_t3 = M_RO | M_AI;
      end
      OP_ADD: begin
        w_t2 = M_MI | M_IO;
        w_t3 = M_RO | M_BI;
        w_t4 = M_AI | M_EO | M_FI;
      end
      OP_SUB: begin
        w_t2 = M_MI | M_IO;
        w_t3 = M_RO | M_BI;
        w_t4 = M_AI | M_EO | M_SU | M_FI;
      end
      OP_STA: begin
        w_t2 = M_MI | M_IO;
        w_t3 = M_RI | M_AO;
      end
      OP_LDI: w_t2 = M_IO | M_AI;
      OP_JMP: w_t2 = M_IO | M_J;
      OP_JC:  w_t2 = i_cf ? (M_IO | M_J) : '0;
      OP_JZ:  w_t2 = i_zf ? (M_IO | M_J) : '0;
      OP_OUT: w_t2 = M_AO | M_OI;
      OP_HLT: w_t2 = M_HLT;
      default: ;
    endcase
  end

  always_comb begin
    o_word = '0;
    case (i_step)
      STEP_W'(0): o_word = FETCH_T0;
      STEP_W'(1): o_word = FETCH_T1;
      STEP_W'(2): o_word = w_t2;
      STEP_W'(3): o_word = w_t3;
      STEP_W'(4): o_word = w_t4;
      default:    o_word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-step counter and RUN/HALT state; gates the microcode word onto the datapath control bus.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned STEP_W    = 3,
  parameter int unsigned NUM_STEPS = 5,
  parameter bit          EARLY_END = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_clr_n,
  input  logic                i_step_en,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_cf,
  input  logic                i_zf,
  output logic [CTRL_W-1:0]   o_ctrl_state,
  output logic [STEP_W-1:0]   o_step,
  output logic                o_halted,
  output logic                o_fetch
);

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] FIRST_EXEC = STEP_W'(2);

  seq_state_e        r_state;
  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  logic [CTRL_W-1:0] w_rom_word;
  logic [CTRL_W-1:0] w_ctrl;

  microcode_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W)
  ) u_rom (
    .i_opcode (i_opcode),
    .i_step   (r_step),
    .i_cf     (i_cf),
    .i_zf     (i_zf),
    .o_word   (w_rom_word)
  );

  // Reset gates the word directly so the datapath sees 0 without waiting for an edge.
  always_comb begin
    w_ctrl = '0;
    if (!i_clr_n) begin
      w_ctrl = '0;
    end else if (r_state == StHalt) begin
      w_ctrl = M_HLT;
    end else if (i_step_en) begin
      w_ctrl = w_rom_word;
    end
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state  <= StRun;
      r_step   <= '0;
      r_halted <= 1'b0;
    end else if (r_state == StRun && i_step_en) begin
      if (w_ctrl[B_HLT]) begin
        r_state  <= StHalt;
        r_halted <= 1'b1;
      end else if (r_step == LAST_STEP ||
                   (EARLY_END && r_step >= FIRST_EXEC && w_ctrl == '0)) begin
        r_step <= '0;
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  assign o_ctrl_state = w_ctrl;
  assign o_step       = r_step;
  assign o_halted     = r_halted;
  assign o_fetch      = (r_step < FIRST_EXEC);

  a_one_bus_driver: assert property (@(posedge i_clk) disable iff (!i_clr_n)
    $onehot0({w_ctrl[B_RO], w_ctrl[B_IO], w_ctrl[B_AO], w_ctrl[B_EO], w_ctrl[B_CO]}));

endmodule
